// File: rtl/spi_master_multi.sv
// ---------------------------------------------------------------------------
// spi_master_multi
//
// SPI master with a CPU-programmable control register and an in-place data
// buffer. One send command shifts up to n_tx words out of the buffer, starting
// at entry 0. Each received word overwrites the entry it was sent from.
// Supports all four CPOL/CPHA modes and a programmable SCLK half-period.
//
// Ports
//   clk_pi      : system clock (only clock of the block)
//   reset_pi    : asynchronous active-high reset
//   wr_pi       : CPU write strobe
//   reg_sel_pi  : 0 = control register, 1 = data buffer
//   entrada_pi  : CPU write data
//   addr_in_pi  : data buffer index for CPU access
//   miso_pi     : serial data in
//   salida_po   : CPU read data (combinational)
//   mosi_o      : serial data out
//   sclk_po     : serial clock
//   cs_po       : active-low chip selects
//
// Control register layout
//   [0] send/busy  [1] cpol  [2] cpha  [3] cs_hold  [7:4] cs_sel
//   [15:8] n_tx    [23:16] clk_div     [31:24] n_rx (read-only)
// ---------------------------------------------------------------------------
module spi_master_multi #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int N_CS   = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_pi,
    input  logic              reset_pi,
    input  logic              wr_pi,
    input  logic              reg_sel_pi,
    input  logic [31:0]       entrada_pi,
    input  logic [ADDR_W-1:0] addr_in_pi,
    input  logic              miso_pi,
    output logic [31:0]       salida_po,
    output logic              mosi_o,
    output logic              sclk_po,
    output logic [N_CS-1:0]   cs_po
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, DONE} state_t;

    localparam logic [6:0] EDGES = 7'(2 * DATA_W);

    state_t state, next_state;

    logic [31:0]       ctrl;
    logic [DATA_W-1:0] buffer [DEPTH];

    logic              send, cpol, cpha, cs_hold;
    logic [3:0]        cs_sel;
    logic [7:0]        n_tx, clk_div, n_rx;

    // Transfer settings captured at accept time so CPU writes cannot disturb them
    logic              cpol_l, cpha_l;
    logic [7:0]        div_l;

    logic [7:0]        div_cnt;
    logic [6:0]        edge_cnt;
    logic [DATA_W-1:0] tx_sr, rx_sr;

    logic              send_ok, tick;
    logic              accept, reject, do_edge, word_end, load_word;
    logic              leading, sample_edge, shift_edge, last_edge;
    logic [DATA_W:0]   rx_ext;
    logic [DATA_W-1:0] rx_next, wb_word, load_data;
    logic [ADDR_W-1:0] load_idx, cur_idx;
    logic              load_cpha;
    logic [31:0]       rd_word;
    logic              unused_bits;

    assign send    = ctrl[0];
    assign cpol    = ctrl[1];
    assign cpha    = ctrl[2];
    assign cs_hold = ctrl[3];
    assign cs_sel  = ctrl[7:4];
    assign n_tx    = ctrl[15:8];
    assign clk_div = ctrl[23:16];
    assign n_rx    = ctrl[31:24];

    assign unused_bits = ^entrada_pi[31:24];

    // A send is only legal if it names a real chip select and a word count that fits the buffer
    assign send_ok = (n_tx != 8'd0) && ({1'b0, n_tx} <= 9'(DEPTH)) && ({1'b0, cs_sel} < 5'(N_CS));

    // One half-period has elapsed when the divider counter reaches the latched clk_div
    assign tick = (div_cnt == div_l);

    // State register
    always_ff @(posedge clk_pi or posedge reset_pi) begin
        if (reset_pi) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the per-cycle strobes that steer the datapath.
    // The first SCLK edge fires at the end of SETUP; after the last edge of a
    // word the block waits one more half-period before leaving SHIFT.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        reject     = 1'b0;
        do_edge    = 1'b0;
        word_end   = 1'b0;
        load_word  = 1'b0;
        case (state)
            IDLE: begin
                if (send) begin
                    if (send_ok) begin
                        accept     = 1'b1;
                        load_word  = 1'b1;
                        next_state = SETUP;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (tick) begin
                    do_edge    = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (edge_cnt == EDGES) begin
                        word_end = 1'b1;
                        if (n_rx < n_tx) begin
                            if (cs_hold) begin
                                load_word  = 1'b1;
                                next_state = SETUP;
                            end else begin
                                next_state = GAP;
                            end
                        end else begin
                            next_state = DONE;
                        end
                    end else begin
                        do_edge = 1'b1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    load_word  = 1'b1;
                    next_state = SETUP;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Edge classification: an edge is leading when an even number of edges came before it.
    // cpha=0 samples on leading edges, cpha=1 on trailing edges; the other edge shifts.
    assign leading     = ~edge_cnt[0];
    assign sample_edge = do_edge & (leading ^ cpha_l);
    assign shift_edge  = do_edge & ~(leading ^ cpha_l);
    assign last_edge   = do_edge & (edge_cnt == EDGES - 7'd1);

    assign rx_ext  = {rx_sr, miso_pi};
    assign rx_next = rx_ext[DATA_W-1:0];
    // For cpha=1 the final edge is itself a sample edge, so include that bit in the write-back
    assign wb_word = sample_edge ? rx_next : rx_sr;

    // On accept n_rx is being cleared this same edge, so the first word always comes from entry 0
    assign cur_idx   = n_rx[ADDR_W-1:0];
    assign load_idx  = accept ? '0 : cur_idx;
    assign load_data = buffer[load_idx];
    assign load_cpha = accept ? cpha : cpha_l;

    // Control register, pin drivers and shift datapath
    always_ff @(posedge clk_pi or posedge reset_pi) begin
        if (reset_pi) begin
            ctrl     <= 32'd0;
            sclk_po  <= 1'b0;
            mosi_o   <= 1'b0;
            cs_po    <= '1;
            cpol_l   <= 1'b0;
            cpha_l   <= 1'b0;
            div_l    <= 8'd0;
            div_cnt  <= 8'd0;
            edge_cnt <= 7'd0;
            tx_sr    <= '0;
            rx_sr    <= '0;
        end else begin
            if (wr_pi && !reg_sel_pi && !send) begin
                ctrl[23:0] <= entrada_pi[23:0];
            end

            if (reject) begin
                ctrl[0] <= 1'b0;
            end

            if (accept) begin
                cpol_l       <= cpol;
                cpha_l       <= cpha;
                div_l        <= clk_div;
                ctrl[31:24]  <= 8'd0;
            end

            if (accept || tick) begin
                div_cnt <= 8'd0;
            end else if (state == SETUP || state == SHIFT || state == GAP) begin
                div_cnt <= div_cnt + 8'd1;
            end

            if (state == IDLE) begin
                sclk_po <= cpol;
            end

            if (load_word) begin
                edge_cnt <= 7'd0;
                rx_sr    <= '0;
                tx_sr    <= load_cpha ? load_data : (load_data << 1);
                cs_po    <= ~(N_CS'(1) << cs_sel);
                if (!load_cpha) begin
                    mosi_o <= load_data[DATA_W-1];
                end
            end

            if (do_edge) begin
                sclk_po  <= ~sclk_po;
                edge_cnt <= edge_cnt + 7'd1;
            end

            if (shift_edge) begin
                mosi_o <= tx_sr[DATA_W-1];
                tx_sr  <= tx_sr << 1;
            end

            if (sample_edge) begin
                rx_sr <= rx_next;
            end

            if (last_edge) begin
                ctrl[31:24] <= n_rx + 8'd1;
            end

            if (word_end && next_state != SETUP) begin
                cs_po <= '1;
            end

            if (word_end && next_state == DONE) begin
                ctrl[0] <= 1'b0;
            end
        end
    end

    // Buffer storage is deliberately not reset so data survives an aborted transfer.
    // CPU writes and write-backs never coincide because the CPU is locked out while busy.
    always_ff @(posedge clk_pi) begin
        if (last_edge) begin
            buffer[cur_idx] <= wb_word;
        end else if (wr_pi && reg_sel_pi && !send) begin
            buffer[addr_in_pi] <= entrada_pi[DATA_W-1:0];
        end
    end

    // Combinational CPU read path
    always_comb begin
        rd_word               = 32'd0;
        rd_word[DATA_W-1:0]   = buffer[addr_in_pi];
        salida_po             = reg_sel_pi ? rd_word : ctrl;
    end

endmodule

// File: tb/tb_spi_master_multi.sv
// ---------------------------------------------------------------------------
// tb_spi_master_multi
//
// Directed bench for spi_master_multi. A table of transfer records drives the
// main instance (DATA_W=8, DEPTH=32, N_CS=4) through the four SPI modes and
// multi-word transfers; hand-written sequences cover rejection, busy lockout,
// mid-transfer reset and a DATA_W=32 loopback on a second instance.
// ---------------------------------------------------------------------------
module tb_spi_master_multi;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;
    localparam int N_CS   = 4;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr;
    logic              reg_sel;
    logic [31:0]       entrada;
    logic [ADDR_W-1:0] addr;
    wire               miso;
    wire  [31:0]       salida;
    wire               mosi;
    wire               sclk;
    wire  [N_CS-1:0]   cs;

    logic              wr32;
    logic              reg_sel32;
    logic [31:0]       entrada32;
    logic [1:0]        addr32;
    wire  [31:0]       salida32;
    wire               mosi32;
    wire               sclk32;
    wire  [0:0]        cs32;

    int vectors     = 0;
    int miscompares = 0;

    // Slave model state
    logic        loopback    = 1'b1;
    logic        slave_miso  = 1'b0;
    logic        tb_cpha     = 1'b0;
    logic [23:0] slave_reply = 24'd0;
    int          s_word      = 0;
    int          s_ecnt      = 0;
    int          s_idx       = 7;
    logic        s_prev_act  = 1'b0;
    logic        s_prev_sclk = 1'b0;
    logic        s_act;
    logic [7:0]  s_tmp;

    typedef struct {
        string      name;
        bit         cpol;
        bit         cpha;
        bit         hold;
        bit         loop;
        bit         chk_mosi;
        logic [3:0] cs_sel;
        logic [7:0] div;
        logic [7:0] n_tx;
        logic [23:0] tx;
        logic [23:0] reply;
        logic [23:0] exp_rx;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    assign miso = loopback ? mosi : slave_miso;

    spi_master_multi #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .N_CS(N_CS), .ADDR_W(ADDR_W)
    ) dut (
        .clk_pi(clk), .reset_pi(rst), .wr_pi(wr), .reg_sel_pi(reg_sel),
        .entrada_pi(entrada), .addr_in_pi(addr), .miso_pi(miso),
        .salida_po(salida), .mosi_o(mosi), .sclk_po(sclk), .cs_po(cs)
    );

    spi_master_multi #(
        .DATA_W(32), .DEPTH(4), .N_CS(1), .ADDR_W(2)
    ) dut32 (
        .clk_pi(clk), .reset_pi(rst), .wr_pi(wr32), .reg_sel_pi(reg_sel32),
        .entrada_pi(entrada32), .addr_in_pi(addr32), .miso_pi(mosi32),
        .salida_po(salida32), .mosi_o(mosi32), .sclk_po(sclk32), .cs_po(cs32)
    );

    function automatic logic [7:0] replyByte(input int i);
        logic [23:0] r;
        r = slave_reply;
        if (i < 3) return r[8*i +: 8];
        return 8'h00;
    endfunction

    // SPI slave: presents reply words MSB first, shifting on the edge opposite to sampling
    always @(sclk or cs) begin
        s_act = (cs !== 4'hF);
        if (s_act && !s_prev_act) begin
            s_ecnt = 0;
            s_idx  = 7;
            if (!tb_cpha) begin
                s_tmp      = replyByte(s_word);
                slave_miso = s_tmp[7];
            end
        end else if (s_act && (sclk !== s_prev_sclk)) begin
            s_ecnt++;
            if (s_ecnt == 2 * DATA_W) begin
                s_word++;
                s_ecnt = 0;
                s_idx  = 7;
                if (!tb_cpha) begin
                    s_tmp      = replyByte(s_word);
                    slave_miso = s_tmp[7];
                end
            end else if (s_ecnt % 2 == 1) begin
                if (tb_cpha) begin
                    s_tmp      = replyByte(s_word);
                    slave_miso = s_tmp[s_idx];
                    s_idx--;
                end
            end else begin
                if (!tb_cpha) begin
                    s_idx--;
                    s_tmp      = replyByte(s_word);
                    slave_miso = s_tmp[s_idx];
                end
            end
        end
        s_prev_act  = s_act;
        s_prev_sclk = sclk;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] ctrlWord(input bit snd, input bit pol, input bit pha,
                                             input bit hld, input logic [3:0] sel,
                                             input logic [7:0] ntx, input logic [7:0] div);
        return {8'h00, div, ntx, sel, hld, pha, pol, snd};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic cpuWrite(input bit sel, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        wr      = 1'b1;
        reg_sel = sel;
        addr    = a;
        entrada = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic cpuRead(input bit sel, input logic [ADDR_W-1:0] a, output logic [31:0] d);
        reg_sel = sel;
        addr    = a;
        @(negedge clk);
        d = salida;
    endtask

    task automatic waitIdle(input int limit, output int cycles, output bit done);
        reg_sel = 1'b0;
        cycles  = 0;
        done    = 1'b0;
        while (!done && cycles < limit) begin
            @(posedge clk);
            #1;
            cycles++;
            if (salida[0] == 1'b0) done = 1'b1;
        end
    endtask

    // Runs one table record end to end and checks timing, pins and the written-back data
    task automatic applyStimulus(input vec_t v);
        int          h, n, cycles, edges, first_edge, cs_bad, gap, mosi_bad, exp_cycles, bit_i;
        bit          done;
        logic        prev_s;
        logic [3:0]  exp_cs;
        logic [7:0]  b0;
        logic [31:0] rd;

        h      = int'(v.div) + 1;
        n      = int'(v.n_tx);
        exp_cs = ~(4'b0001 << v.cs_sel);
        b0     = v.tx[7:0];

        tb_cpha     = v.cpha;
        loopback    = v.loop;
        slave_reply = v.reply;
        s_word      = 0;

        for (int k = 0; k < n; k++) begin
            cpuWrite(1'b1, ADDR_W'(k), {24'd0, v.tx[8*k +: 8]});
        end
        cpuWrite(1'b0, '0, ctrlWord(1'b0, v.cpol, v.cpha, v.hold, v.cs_sel, v.n_tx, v.div));
        @(posedge clk);
        #1;
        checkOutput({v.name, " idle sclk"}, {31'd0, sclk}, {31'd0, v.cpol});

        cpuWrite(1'b0, '0, ctrlWord(1'b1, v.cpol, v.cpha, v.hold, v.cs_sel, v.n_tx, v.div));
        reg_sel    = 1'b0;
        cycles     = 0;
        done       = 1'b0;
        edges      = 0;
        first_edge = 0;
        cs_bad     = 0;
        gap        = 0;
        mosi_bad   = 0;
        prev_s     = sclk;
        while (!done && cycles < 2000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (sclk !== prev_s) begin
                edges++;
                if (first_edge == 0) first_edge = cycles;
            end
            prev_s = sclk;
            if (salida[0] == 1'b0) begin
                done = 1'b1;
            end else if (cs === 4'hF) begin
                gap++;
            end else if (cs !== exp_cs) begin
                cs_bad++;
            end
            if (v.chk_mosi && cycles <= 16 * h) begin
                bit_i = 7 - (cycles - 1) / (2 * h);
                if (mosi !== b0[bit_i]) mosi_bad++;
            end
        end

        exp_cycles = 1 + n * (2 * DATA_W + 1) * h + (v.hold ? 0 : (n - 1) * h);
        checkOutput({v.name, " completed"}, {31'd0, done}, 32'd1);
        checkOutput({v.name, " busy cycles"}, 32'(cycles), 32'(exp_cycles));
        checkOutput({v.name, " sclk edges"}, 32'(edges), 32'(2 * DATA_W * n));
        checkOutput({v.name, " first edge"}, 32'(first_edge), 32'(1 + h));
        checkOutput({v.name, " cs pattern"}, 32'(cs_bad), 32'd0);
        checkOutput({v.name, " cs gap"}, 32'(gap), 32'(v.hold ? 0 : (n - 1) * h));
        checkOutput({v.name, " sclk at end"}, {31'd0, sclk}, {31'd0, v.cpol});
        if (v.chk_mosi) begin
            checkOutput({v.name, " mosi bits"}, 32'(mosi_bad), 32'd0);
        end

        cpuRead(1'b0, '0, rd);
        checkOutput({v.name, " n_rx"}, {24'd0, rd[31:24]}, {24'd0, v.n_tx});
        checkOutput({v.name, " send"}, {31'd0, rd[0]}, 32'd0);
        for (int k = 0; k < n; k++) begin
            cpuRead(1'b1, ADDR_W'(k), rd);
            checkOutput({v.name, " buffer"}, rd, {24'd0, v.exp_rx[8*k +: 8]});
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        prev_s;
        logic        pre_busy;
        int          cycles, act, cs_low;
        bit          done;
        logic [31:0] rej_words [3];

        // name, cpol, cpha, hold, loop, chk_mosi, cs_sel, div, n_tx, tx, reply, exp_rx
        vecs[0] = '{"mode0 loop A5", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 8'd1, 8'd1,
                    24'h0000A5, 24'h000000, 24'h0000A5};
        vecs[1] = '{"mode1 3C",      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1, 8'd1,
                    24'h00005A, 24'h00003C, 24'h00003C};
        vecs[2] = '{"mode2 3C",      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 8'd2, 8'd1,
                    24'h000081, 24'h00003C, 24'h00003C};
        vecs[3] = '{"mode3 3C",      1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 8'd0, 8'd1,
                    24'h0000C3, 24'h00003C, 24'h00003C};
        vecs[4] = '{"3w gap",        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1, 8'd3,
                    24'h332211, 24'hCCDDEE, 24'hCCDDEE};
        vecs[5] = '{"3w hold",       1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 8'd0, 8'd3,
                    24'h332211, 24'hCCDDEE, 24'hCCDDEE};

        rst       = 1'b1;
        wr        = 1'b0;
        reg_sel   = 1'b0;
        entrada   = 32'd0;
        addr      = '0;
        wr32      = 1'b0;
        reg_sel32 = 1'b0;
        entrada32 = 32'd0;
        addr32    = 2'd0;

        // Reset state
        @(negedge clk);
        checkOutput("reset cs", {28'd0, cs}, 32'h0000000F);
        checkOutput("reset sclk", {31'd0, sclk}, 32'd0);
        checkOutput("reset mosi", {31'd0, mosi}, 32'd0);
        checkOutput("reset ctrl", salida, 32'd0);
        checkOutput("reset cs32", {31'd0, cs32}, 32'd1);
        rst = 1'b0;
        cpuRead(1'b0, '0, rd);
        checkOutput("ctrl after reset", rd, 32'd0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
        end

        // Rejected sends: clear next cycle with no pin activity
        loopback     = 1'b1;
        rej_words[0] = ctrlWord(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0,  8'd0);
        rej_words[1] = ctrlWord(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd33, 8'd0);
        rej_words[2] = ctrlWord(1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 8'd1,  8'd0);
        for (int r = 0; r < 3; r++) begin
            cpuWrite(1'b0, '0, ctrlWord(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1, 8'd0));
            @(posedge clk);
            #1;
            prev_s = sclk;
            cpuWrite(1'b0, '0, rej_words[r]);
            pre_busy = salida[0];
            checkOutput("reject busy at write", {31'd0, pre_busy}, 32'd1);
            act = 0;
            for (int c = 0; c < 4; c++) begin
                @(posedge clk);
                #1;
                if (sclk !== prev_s || cs !== 4'hF) act++;
                if (c == 0) checkOutput("reject send cleared", {31'd0, salida[0]}, 32'd0);
            end
            checkOutput("reject pin activity", 32'(act), 32'd0);
        end

        // Busy lockout: buffer and control writes during a transfer are dropped
        cpuWrite(1'b1, 5'd1, 32'h00000077);
        cpuWrite(1'b1, 5'd0, 32'h00000042);
        cpuWrite(1'b0, '0, ctrlWord(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1, 8'd3));
        repeat (5) @(posedge clk);
        #1;
        cpuWrite(1'b1, 5'd1, 32'h000000FF);
        cpuWrite(1'b0, '0, ctrlWord(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd9, 8'd3));
        waitIdle(500, cycles, done);
        checkOutput("busy transfer done", {31'd0, done}, 32'd1);
        cpuRead(1'b1, 5'd1, rd);
        checkOutput("busy buffer write ignored", rd, 32'h00000077);
        cpuRead(1'b1, 5'd0, rd);
        checkOutput("busy loopback entry0", rd, 32'h00000042);
        cpuRead(1'b0, '0, rd);
        checkOutput("busy ctrl write ignored", {24'd0, rd[15:8]}, 32'd1);

        // Reset in the middle of a mode 2 transfer
        cpuWrite(1'b0, '0, ctrlWord(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 8'd1, 8'd1));
        @(posedge clk);
        #1;
        cpuWrite(1'b0, '0, ctrlWord(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 8'd1, 8'd1));
        repeat (9) @(posedge clk);
        #1;
        checkOutput("mid cs low", {28'd0, cs}, 32'h0000000B);
        checkOutput("mid sclk high", {31'd0, sclk}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset cs", {28'd0, cs}, 32'h0000000F);
        checkOutput("async reset sclk", {31'd0, sclk}, 32'd0);
        checkOutput("async reset mosi", {31'd0, mosi}, 32'd0);
        cpuRead(1'b0, '0, rd);
        checkOutput("async reset ctrl", rd, 32'd0);
        rst = 1'b0;
        cpuRead(1'b1, 5'd0, rd);
        checkOutput("reset keeps entry0", rd, 32'h00000042);
        cpuRead(1'b1, 5'd1, rd);
        checkOutput("reset keeps entry1", rd, 32'h00000077);

        // DATA_W=32 loopback on the second instance
        wr32      = 1'b1;
        reg_sel32 = 1'b1;
        addr32    = 2'd0;
        entrada32 = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        reg_sel32 = 1'b0;
        entrada32 = ctrlWord(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1, 8'd0);
        @(posedge clk);
        #1;
        wr32   = 1'b0;
        cycles = 0;
        cs_low = 0;
        done   = 1'b0;
        while (!done && cycles < 300) begin
            @(posedge clk);
            #1;
            cycles++;
            if (salida32[0] == 1'b0) done = 1'b1;
            else if (cs32 == 1'b0) cs_low++;
        end
        checkOutput("w32 completed", {31'd0, done}, 32'd1);
        checkOutput("w32 busy cycles", 32'(cycles), 32'd66);
        checkOutput("w32 cs low cycles", 32'(cs_low), 32'd65);
        checkOutput("w32 n_rx", {24'd0, salida32[31:24]}, 32'd1);
        reg_sel32 = 1'b1;
        @(negedge clk);
        checkOutput("w32 buffer", salida32, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_master_multi.md
# spi_master_multi

Parametrised SPI master peripheral for the RISC-V SoC bus. It is the successor to the single-mode SPI block and adds configurable word width, buffer depth, chip-select count, all four CPOL/CPHA modes and a programmable SCLK divider. The CPU programs a control register and a data buffer through the shared write/reg-select port. A single send command then exchanges up to DEPTH words in place: each received word overwrites the buffer entry it was sent from.

## Interface
- DATA_W, 8: bits per SPI word, 1..32.
- DEPTH, 32: data buffer entries, power of two, 2..256.
- N_CS, 4: chip-select lines, 1..16.
- ADDR_W, $clog2(DEPTH): buffer address width.
- clk_pi  in  1: system clock. This is the block's single clock.
- reset_pi  in  1: reset, asynchronous and active-high.
- wr_pi  in  1: CPU write strobe.
- reg_sel_pi  in  1: register select. 0 selects the control register; 1 selects the data buffer.
- entrada_pi  in  32: CPU write data.
- addr_in_pi  in  ADDR_W: data buffer index.
- miso_pi  in  1: serial data in.
- salida_po  out  32: CPU read data.
- mosi_o  out  1: serial data out.
- sclk_po  out  1: serial clock.
- cs_po  out  N_CS: chip selects, active-low.

## Operation
Control register fields. All are R/W unless noted.
- [0] send: the CPU writes 1 to start. Hardware clears it when the transfer ends or is rejected. It reads as busy.
- [1] cpol; [2] cpha.
- [3] cs_hold: 1 keeps CS low between words of one transfer.
- [7:4] cs_sel: index of the chip select to drive.
- [15:8] n_tx: number of words to send, starting at buffer entry 0.
- [23:16] clk_div: sets the SCLK half-period to clk_div+1 clk_pi cycles.
- [31:24] n_rx: read-only count of words completed. It is cleared when a transfer is accepted.

CPU access rules:
- Reads are combinational and allowed in any cycle. salida_po returns the control register when reg_sel_pi=0, and buffer[addr_in_pi] zero-extended to 32 bits when reg_sel_pi=1.
- While busy, CPU writes to the control register and to the buffer are ignored.
- Send is rejected if n_tx=0, n_tx>DEPTH, or cs_sel>=N_CS. On rejection, send clears on the next clock and the SPI pins do not move.

FSM states: IDLE, SETUP, SHIFT, GAP, DONE.
- IDLE: sclk_po=cpol; all cs_po bits high.
- IDLE -> SETUP on an accepted send. cs_po[cs_sel] goes low. For cpha=0, mosi_o is driven with the MSB of the current word. The block waits one half-period.
- SETUP -> SHIFT: the block generates 2·DATA_W SCLK edges, MSB first.
  - cpha=0: sample miso on leading edges; shift mosi on trailing edges.
  - cpha=1: shift mosi on leading edges; sample miso on trailing edges.
- At the end of SHIFT, the received word is written to buffer[index] and n_rx increments.
- SHIFT -> SETUP if words remain and cs_hold=1. CS stays low.
- SHIFT -> GAP if words remain and cs_hold=0. CS goes high for one half-period, then the block enters SETUP.
- SHIFT -> DONE after the last word. CS goes high and send clears. DONE -> IDLE next cycle.
- cpol, cpha and clk_div are latched on accept, so mid-transfer changes are impossible.

## Timing
- Reset: all outputs take their reset values immediately and asynchronously, including mid-transfer, which aborts.
  - Control register, mosi_o and sclk_po reset to 0.
  - cs_po resets to all-ones.
  - The FSM returns to IDLE.
  - The buffer is not reset; its contents are preserved.
- Writes take effect on the clk_pi edge where wr_pi=1.
- For an accepted send written at edge t:
  - CS asserts at t+1.
  - The first SCLK edge occurs at t+1+H, where H=clk_div+1.
- One word takes (2·DATA_W+1)·H cycles when cs_hold=1, plus H cycles of GAP when cs_hold=0.
- The write-back of word k and the n_rx increment occur on the clock edge of the final SCLK edge of that word.
- A CPU read of the same entry in that cycle returns the old value.
- Busy reads 0 on the cycle CS deasserts after the last word.

## Test plan
- Reset with cs_po high, sclk 0, then read control -> 0x00000000. Assert reset mid-SHIFT -> cs_po=4'b1111 and sclk_po=0 in the same cycle. Buffer entries are unchanged.
- DATA_W=8, mode 0, clk_div=1, buffer[0]=0xA5 with MISO looped to MOSI; send n_tx=1, cs_sel=2 -> cs_po=4'b1011 during the transfer. mosi_o carries 1,0,1,0,0,1,0,1, each bit held 4 clk_pi cycles. buffer[0] reads 0xA5, n_rx=1, send=0.
- Modes 1/2/3 with a slave model returning 0x3C -> buffer[0]=0x3C. SCLK idles at cpol. The sampling edge matches cpha.
- n_tx=3, cs_hold=0, buffer={0x11,0x22,0x33}, slave returns the inverted byte -> CS pulses high for H cycles between words. Buffer reads {0xEE,0xDD,0xCC}, n_rx=3. Repeat with cs_hold=1 -> CS stays low throughout.
- Rejections: n_tx=0, n_tx=DEPTH+1 and cs_sel=N_CS each clear send on the next cycle with no SCLK/CS activity. A buffer write of 0xFF to entry 1 while busy is ignored.
- DATA_W=32, DEPTH=4, N_CS=1: 0xDEADBEEF loopback -> read back 0xDEADBEEF, n_rx=1.
